// File: rtl/barrel_shift_pipe_if.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe_if
// Purpose : Handshake and data bundle for the pipelined barrel shifter.
// Signals : in_valid/in_ready/in/s/mode  - operand side (master drives)
//           out_valid/out_ready/op       - result side (slave drives result)
// Modports: slave  - the shifter itself
//           master - operand source / result consumer (e.g. a testbench)
// ---------------------------------------------------------------------------
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic [SHW-1:0]   s;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op;

    modport slave (
        input  in_valid, in, s, mode, out_ready,
        output in_ready, out_valid, op
    );

    modport master (
        output in_valid, in, s, mode, out_ready,
        input  in_ready, out_valid, op
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe
// Purpose : Pipelined barrel shifter, one register stage per shift level.
//           Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Latency SHW cycles,
//           throughput one operation per clock, global stall on backpressure.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - barrel_shift_pipe_if.slave (in_valid/in_ready/in/s/mode,
//                  out_valid/out_ready/op)
// ---------------------------------------------------------------------------
module barrel_shift_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    barrel_shift_pipe_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("barrel_shift_pipe: WIDTH must be a power of 2 and >= 2");
    end

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // Stage registers; index SHW-1 is the output stage.
    logic             r_vld  [SHW];
    logic [WIDTH-1:0] r_data [SHW];
    logic [SHW-1:0]   r_s    [SHW];
    logic [1:0]       r_mode [SHW];
    logic             r_msb  [SHW];

    // Per-stage source operands and shifted result.
    logic             w_src_vld  [SHW];
    logic [WIDTH-1:0] w_src_data [SHW];
    logic [SHW-1:0]   w_src_s    [SHW];
    logic [1:0]       w_src_mode [SHW];
    logic             w_src_msb  [SHW];
    logic [WIDTH-1:0] w_res      [SHW];

    logic w_stall;

    // A valid result the consumer refuses freezes the whole pipe.
    assign w_stall       = r_vld[SHW-1] & ~bus.out_ready;
    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_vld[SHW-1];
    assign bus.op        = r_data[SHW-1];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 2 ** k;

        logic [WIDTH-1:0] w_sll;
        logic [WIDTH-1:0] w_srl;
        logic [WIDTH-1:0] w_sra;
        logic [WIDTH-1:0] w_rol;
        logic [WIDTH-1:0] w_fill;
        logic [WIDTH-1:0] w_shifted;

        if (k == 0) begin : g_first
            // Stalled cycles hold every register, so in_valid alone marks an accept.
            assign w_src_vld[k]  = bus.in_valid;
            assign w_src_data[k] = bus.in;
            assign w_src_s[k]    = bus.s;
            assign w_src_mode[k] = bus.mode;
            assign w_src_msb[k]  = bus.in[WIDTH-1];
        end else begin : g_next
            assign w_src_vld[k]  = r_vld[k-1];
            assign w_src_data[k] = r_data[k-1];
            assign w_src_s[k]    = r_s[k-1];
            assign w_src_mode[k] = r_mode[k-1];
            assign w_src_msb[k]  = r_msb[k-1];
        end

        assign w_sll  = w_src_data[k] << SH;
        assign w_srl  = w_src_data[k] >> SH;
        // SRA fill comes from the original operand MSB carried down the pipe.
        assign w_fill = ~({WIDTH{1'b1}} >> SH);
        assign w_sra  = w_srl | (w_fill & {WIDTH{w_src_msb[k]}});
        assign w_rol  = (w_src_data[k] << SH) | (w_src_data[k] >> (WIDTH - SH));

        always_comb begin
            w_shifted = w_src_data[k];
            if (w_src_s[k][k]) begin
                case (w_src_mode[k])
                    MODE_SLL: w_shifted = w_sll;
                    MODE_SRL: w_shifted = w_srl;
                    MODE_SRA: w_shifted = w_sra;
                    MODE_ROL: w_shifted = w_rol;
                endcase
            end
        end

        assign w_res[k] = w_shifted;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                r_vld[k]  <= 1'b0;
                r_data[k] <= '0;
                r_s[k]    <= '0;
                r_mode[k] <= '0;
                r_msb[k]  <= 1'b0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < SHW; k++) begin
                r_vld[k]  <= w_src_vld[k];
                r_data[k] <= w_res[k];
                r_s[k]    <= w_src_s[k];
                r_mode[k] <= w_src_mode[k];
                r_msb[k]  <= w_src_msb[k];
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.WIDTH(8))  b8 ();
    barrel_shift_pipe_if #(.WIDTH(32)) b32 ();

    barrel_shift_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
    barrel_shift_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

    typedef struct {
        logic [31:0] din;
        int          sh;
        logic [1:0]  md;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q8[$];
    logic [31:0] q32[$];
    int          out_cyc[$];
    int          cyc = 0;
    bit          rec = 1'b0;
    int          n_out8 = 0;
    int          n_out32 = 0;
    logic [31:0] nxt8, nxt32;
    bit          prev_st8 = 1'b0, prev_st32 = 1'b0;
    logic [31:0] prev_op8, prev_op32;
    bit          acc8, acc32;

    // Reference: operand treated as a W-bit number, shifts done in 64-bit arithmetic.
    function automatic logic [31:0] model(input int w, input logic [31:0] x,
                                          input int s, input logic [1:0] m);
        longint unsigned mask, ux, r;
        longint          sx;
        mask = (64'd1 << w) - 64'd1;
        ux   = {32'd0, x} & mask;
        sx   = ux[w-1] ? (longint'(ux) - longint'(64'd1 << w)) : longint'(ux);
        case (m)
            2'd0:    r = ux << s;
            2'd1:    r = ux >> s;
            2'd2:    r = longint'(sx >>> s);
            default: r = (ux << s) | (ux >> (w - s));
        endcase
        return 32'(r & mask);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: observe transfers at the negedge, then advance past the edge.
    task automatic step();
        @(negedge clk);
        acc8  = b8.in_valid && b8.in_ready;
        acc32 = b32.in_valid && b32.in_ready;
        if (acc8)  q8.push_back(nxt8);
        if (acc32) q32.push_back(nxt32);
        if (b8.out_valid && b8.out_ready) begin
            n_out8++;
            if (rec) out_cyc.push_back(cyc);
            if (q8.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL out8_unexpected actual=%h required=none", b8.op);
            end else chk("out8", 32'(b8.op), q8.pop_front());
        end
        if (b32.out_valid && b32.out_ready) begin
            n_out32++;
            if (q32.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL out32_unexpected actual=%h required=none", b32.op);
            end else chk("out32", b32.op, q32.pop_front());
        end
        if (b8.out_valid && !b8.out_ready) begin
            chk("stall_in_ready8", 32'(b8.in_ready), 32'd0);
            if (prev_st8) chk("stall_op_hold8", 32'(b8.op), prev_op8);
        end
        if (b32.out_valid && !b32.out_ready) begin
            chk("stall_in_ready32", 32'(b32.in_ready), 32'd0);
            if (prev_st32) chk("stall_op_hold32", b32.op, prev_op32);
        end
        prev_st8  = b8.out_valid && !b8.out_ready;
        prev_op8  = 32'(b8.op);
        prev_st32 = b32.out_valid && !b32.out_ready;
        prev_op32 = b32.op;
        @(posedge clk); #1;
        cyc++;
    endtask

    // Count edges from the accept edge until out_valid, with the consumer stalled.
    task automatic lat_check(input bit sel, input int want);
        int  n = 0;
        bit  seen = 1'b0;
        b8.in_valid = 1'b0;  b32.in_valid = 1'b0;
        b8.out_ready = 1'b0; b32.out_ready = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sel ? b32.out_valid : b8.out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk(sel ? "latency32" : "latency8", 32'(n), 32'(want));
        prev_st8 = 1'b0; prev_st32 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set8(input bit v, input logic [7:0] x, input int s, input logic [1:0] m);
        b8.in_valid = v; b8.in = x; b8.s = 3'(s); b8.mode = m;
        nxt8 = model(8, 32'(x), s, m);
    endtask

    task automatic set32(input bit v, input logic [31:0] x, input int s, input logic [1:0] m);
        b32.in_valid = v; b32.in = x; b32.s = 5'(s); b32.mode = m;
        nxt32 = model(32, x, s, m);
    endtask

    task automatic drain();
        b8.in_valid = 1'b0; b32.in_valid = 1'b0;
        b8.out_ready = 1'b1; b32.out_ready = 1'b1;
        repeat (8) step();
    endtask

    vec_t tbl8[9];
    vec_t tbl32[3];

    initial begin
        int sent, acc_r8, acc_r32, out_base8, out_base32;

        tbl8[0] = '{32'hF0, 0, 2'd0, 32'hF0};
        tbl8[1] = '{32'hF0, 0, 2'd1, 32'hF0};
        tbl8[2] = '{32'hF0, 0, 2'd2, 32'hF0};
        tbl8[3] = '{32'hF0, 0, 2'd3, 32'hF0};
        tbl8[4] = '{32'hF0, 1, 2'd0, 32'hE0};
        tbl8[5] = '{32'hF0, 3, 2'd1, 32'h1E};
        tbl8[6] = '{32'hF0, 2, 2'd2, 32'hFC};
        tbl8[7] = '{32'hF0, 5, 2'd3, 32'h1E};
        tbl8[8] = '{32'h70, 7, 2'd2, 32'h00};
        tbl32[0] = '{32'h8000_0001, 31, 2'd2, 32'hFFFF_FFFF};
        tbl32[1] = '{32'h8000_0001, 1,  2'd3, 32'h0000_0003};
        tbl32[2] = '{32'h8000_0001, 31, 2'd0, 32'h8000_0000};

        set8(1'b0, 8'h00, 0, 2'd0);
        set32(1'b0, 32'h0, 0, 2'd0);
        b8.out_ready = 1'b0; b32.out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid8", 32'(b8.out_valid), 32'd0);
        chk("rst_op8", 32'(b8.op), 32'd0);
        chk("rst_in_ready8", 32'(b8.in_ready), 32'd1);
        chk("rst_out_valid32", 32'(b32.out_valid), 32'd0);
        #19 rst = 1'b0;
        @(posedge clk); #1;

        // Passthrough latency, both widths
        set8(1'b1, 8'hF0, 0, 2'd0);
        step();
        lat_check(1'b0, 2);
        chk("lat_op8", 32'(b8.op), 32'hF0);
        drain();
        set32(1'b1, 32'h8000_0001, 31, 2'd2);
        step();
        lat_check(1'b1, 4);
        drain();

        // Table: passthrough in every mode plus mode sweep, back-to-back
        b8.out_ready = 1'b1;
        rec = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set8(1'b1, tbl8[i].din[7:0], tbl8[i].sh, tbl8[i].md);
            nxt8 = tbl8[i].exp;
            step();
        end
        drain();
        rec = 1'b0;
        chk("sweep_count", 32'(out_cyc.size()), 32'd9);
        if (out_cyc.size() > 0)
            chk("sweep_consecutive", 32'(out_cyc[$] - out_cyc[0]), 32'd8);

        for (int i = 0; i < 3; i++) begin
            set32(1'b1, tbl32[i].din, tbl32[i].sh, tbl32[i].md);
            nxt32 = tbl32[i].exp;
            step();
        end
        drain();

        // Backpressure: 6 ops with a 4-cycle stall mid-stream
        sent = 0;
        out_base8 = n_out8;
        for (int c = 0; c < 40 && (sent < 6 || q8.size() > 0); c++) begin
            set8(sent < 6, 8'(sent * 37 + 5), sent % 8, 2'(sent % 4));
            b8.out_ready = !(c >= 4 && c < 8);
            step();
            if (acc8) sent++;
        end
        chk("bp_sent", 32'(sent), 32'd6);
        chk("bp_received", 32'(n_out8 - out_base8), 32'd6);
        drain();

        // Reset with three ops in flight
        b8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set8(1'b1, 8'hFF, 0, 2'd0);
            step();
        end
        b8.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("midrst_op", 32'(b8.op), 32'd0);
        q8.delete();
        prev_st8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(b8.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        set8(1'b1, 8'hA5, 3, 2'd3);
        step();
        lat_check(1'b0, 2);
        chk("post_rst_op", 32'(b8.op), 32'h2D);
        drain();

        // Randomised traffic on both widths
        acc_r8 = 0; acc_r32 = 0;
        out_base8 = n_out8; out_base32 = n_out32;
        for (int c = 0; c < 20000 && (acc_r8 < 1000 || acc_r32 < 1000); c++) begin
            set8((acc_r8 < 1000) && ($urandom_range(0, 3) != 0), 8'($urandom),
                 int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            set32((acc_r32 < 1000) && ($urandom_range(0, 3) != 0), $urandom,
                  int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            b8.out_ready  = ($urandom_range(0, 3) != 0);
            b32.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc8)  acc_r8++;
            if (acc32) acc_r32++;
        end
        drain();
        chk("rand_in8", 32'(acc_r8), 32'd1000);
        chk("rand_out8", 32'(n_out8 - out_base8), 32'd1000);
        chk("rand_in32", 32'(acc_r32), 32'd1000);
        chk("rand_out32", 32'(n_out32 - out_base32), 32'd1000);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        chk("q32_empty", 32'(q32.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
